// File: rtl/conv_sequencer.sv
// conv_sequencer: address/enable sequencer for a 1-D convolution engine.
// After the x and f buffers are both full, the sequencer walks each output
// window j = 0..N-M. For each window it issues M read addresses to the
// synchronous-read buffers. It drives the external accumulator's enable one
// cycle behind the address, to match the read latency. It then presents the
// result on a valid/ready handshake. A one-cycle conv_done pulse marks the
// end of the whole vector.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   read_done_x  x buffer full (level, sampled only while idle)
//   read_done_f  f buffer full (level, sampled only while idle)
//   m_ready_y    downstream accepts the presented result
//   addr_x       x buffer read address (j + k)
//   addr_f       f buffer read address (k)
//   en_acc       accumulator adds x_data*f_data at the next edge
//   clr_acc      accumulator zeroes at the next edge (wins over en_acc)
//   m_valid_y    accumulator holds a complete output
//   conv_done    one-cycle pulse once every output was delivered
//   busy         sequencer is not idle
//   out_idx      index j of the output being computed or presented
module conv_sequencer #(
    parameter int unsigned N    = 8,
    parameter int unsigned M    = 4,
    parameter int unsigned AW_X = 3,
    parameter int unsigned AW_F = 2,
    parameter int unsigned OW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            read_done_x,
    input  logic            read_done_f,
    input  logic            m_ready_y,
    output logic [AW_X-1:0] addr_x,
    output logic [AW_F-1:0] addr_f,
    output logic            en_acc,
    output logic            clr_acc,
    output logic            m_valid_y,
    output logic            conv_done,
    output logic            busy,
    output logic [OW-1:0]   out_idx
);

    localparam int unsigned LAST_K = M - 1;
    localparam int unsigned LAST_J = N - M;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;

    // addr_f doubles as the tap counter k, and out_idx doubles as the window
    // index j. addr_x is kept equal to j + k by incrementing it with k.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_x    <= '0;
            addr_f    <= '0;
            en_acc    <= 1'b0;
            clr_acc   <= 1'b1;
            m_valid_y <= 1'b0;
            conv_done <= 1'b0;
            busy      <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    en_acc    <= 1'b0;
                    clr_acc   <= 1'b1;
                    m_valid_y <= 1'b0;
                    conv_done <= 1'b0;
                    if (read_done_x && read_done_f) begin
                        state   <= MAC;
                        busy    <= 1'b1;
                        clr_acc <= 1'b0;
                        addr_x  <= '0;
                        addr_f  <= '0;
                        out_idx <= '0;
                    end
                end

                // Every MAC cycle issues an address, so the next cycle
                // accumulates the data returned for it.
                MAC: begin
                    en_acc  <= 1'b1;
                    clr_acc <= 1'b0;
                    if (addr_f == AW_F'(LAST_K)) begin
                        state <= DRAIN;
                    end else begin
                        addr_f <= addr_f + AW_F'(1);
                        addr_x <= addr_x + AW_X'(1);
                    end
                end

                // The last tap's data is accumulated here; no new address.
                DRAIN: begin
                    en_acc    <= 1'b0;
                    m_valid_y <= 1'b1;
                    state     <= OUT;
                end

                // Stalled: everything holds, so the accumulator stays stable.
                // The clear is registered on the handshake edge. It lands in
                // the next window's first MAC cycle, where en_acc is still low.
                OUT: begin
                    if (m_ready_y) begin
                        m_valid_y <= 1'b0;
                        clr_acc   <= 1'b1;
                        if (out_idx == OW'(LAST_J)) begin
                            state     <= DONE;
                            conv_done <= 1'b1;
                        end else begin
                            state   <= MAC;
                            out_idx <= out_idx + OW'(1);
                            addr_x  <= AW_X'(out_idx) + AW_X'(1);
                            addr_f  <= '0;
                        end
                    end
                end

                DONE: begin
                    conv_done <= 1'b0;
                    busy      <= 1'b0;
                    clr_acc   <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
